dual_fetch_buffer: RTL and testbench
====================================

// Module: dual_fetch_buffer
// PURPOSE
// - Feeds instruction pairs into S0 (DECODE) of the dual-issue P0/P1 pipeline; it is the consumer of the hazard unit's fetch_next.
// - Fetches aligned instruction pairs from instruction memory and buffers them in a FIFO.
// - Presents the oldest two instructions as the S0 pair, then pops them when fetch_next=1.
// - Handles redirect (branch/PC load) by flushing and discarding any in-flight response.
// PARAMETERS
// - INSN_W  16  instruction width
// - ADDR_W  9   instruction address width, in instruction units
// - DEPTH   8   FIFO entries, in instructions; power of 2, >=4
// PORTS
// - clk          in   1         clock, rising edge
// - rst_n        in   1         asynchronous active-low reset
// - redirect     in   1         load new fetch PC; flushes the buffer
// - redirect_pc  in   ADDR_W    new PC; may be odd
// - halt         in   1         stop issuing new memory requests; the buffer keeps draining
// - mem_req      out  1         request one pair; held 1 cycle per request
// - mem_addr     out  ADDR_W    pair address; bit0 always 0
// - mem_rvalid   in   1         response valid; arrives 1..N cycles after mem_req
// - mem_rdata    in   2*INSN_W  [INSN_W-1:0] = insn at addr, upper half = insn at addr+1
// - s0_insn0     out  INSN_W    oldest instruction, goes to P0
// - s0_insn1     out  INSN_W    next instruction, goes to P1
// - s0_valid     out  2         bit0 = insn0 valid, bit1 = insn1 valid
// - fetch_next   in   1         from the hazard unit; pop the presented valid instructions
// BEHAVIOUR
// - Reset: fetch_pc=0, count=0, rd/wr pointers=0, state=RUN; mem_req=0, mem_addr=0, s0_valid=0, s0_insn*=0.
// - FSM states:
//   - RUN:   may request.
//   - WAIT:  one request outstanding.
//   - DRAIN: outstanding response is to be discarded.
// - RUN->WAIT: mem_req=1 when !halt, !redirect, and free slots >=2.
// - WAIT->RUN: on mem_rvalid. Push 2 instructions; push only the upper one if the skip_lo flag is set. fetch_pc += 2 (aligned).
// - WAIT->DRAIN: on redirect without mem_rvalid in the same cycle. DRAIN->RUN on mem_rvalid; that data is dropped.
// - Redirect in the same cycle as mem_rvalid: drop the data, go to RUN.
// - Only one outstanding request at a time; mem_req never asserts in WAIT or DRAIN.
// - Redirect (any state):
//   - count, pointers and s0_valid go to 0 next cycle.
//   - fetch_pc = {redirect_pc[ADDR_W-1:1],1'b0}; skip_lo = redirect_pc[0].
//   - A concurrent fetch_next is ignored.
// - skip_lo clears after the first accepted response.
// - Output timing: s0_* are combinational from the FIFO head, so latency is 0 cycles from buffer to S0.
//   - s0_valid = 2'b11 if count>=2, 2'b01 if count==1, 2'b00 if empty.
// - Pop: fetch_next pops popcount(s0_valid) entries, 0..2. fetch_next with s0_valid=0 is a no-op.
// - Push and pop in the same cycle: count_next = count + pushed - popped. Free-slot check uses the current count.
// - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
// - A push of 2 at wr_ptr=DEPTH-1 writes entries DEPTH-1 and 0.
// - Overflow cannot occur by construction. Assert: count <= DEPTH.
// - fetch_pc wraps modulo 2^ADDR_W.
// - halt only blocks new requests; a response already outstanding is still accepted.
// - Reset mid-request: any later mem_rvalid while in RUN with no request is ignored. Assert in simulation.
// STRUCTURE
// - Shared package `core_pkg` holds:
//   - typedefs: insn_t (logic [INSN_W-1:0]), iaddr_t
//   - fetch FSM enum: fetch_state_e {F_RUN, F_WAIT, F_DRAIN}
//   - constant: NOP_INSN
// - One sub-module, `pair_fifo`: circular buffer with 2-wide push/pop, count output and head/head+1 read ports.
// - The FSM and PC logic stay in the top module.
// TESTING
// - Reset, 1-cycle memory, fetch_next=1 always:
//   - mem_addr sequence 0,2,4.
//   - s0_valid=11 with insns {M[0],M[1]}, then {M[2],M[3]}, ...
// - fetch_next=0 for 10 cycles:
//   - count saturates at DEPTH=8; mem_req stays 0 once free slots <2.
//   - Releasing fetch_next resumes fetch with no lost or duplicated instructions.
// - redirect_pc=5 while WAIT and rvalid delayed 3 cycles:
//   - The stale response is dropped.
//   - Next mem_addr=4; s0_insn0=M[5], then the pair M[6]/M[7].
// - redirect in the same cycle as mem_rvalid and fetch_next:
//   - Buffer is empty next cycle (s0_valid=00).
//   - Data is dropped; the next request goes to the new PC.
// - Wrap: fill until wr_ptr=7, then push 2 -> entries 7 and 0 are written; S0 order is preserved across the wrap.
// - halt=1 with one request outstanding:
//   - The response is accepted and mem_req stays 0 afterwards.
//   - The buffer drains to s0_valid=00; deasserting halt resumes from fetch_pc.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and constants for the fetch front end of the dual-issue core.
package core_pkg;

  localparam int INSN_WIDTH = 16;
  localparam int ADDR_WIDTH = 9;

  typedef logic [INSN_WIDTH-1:0] insn_t;
  typedef logic [ADDR_WIDTH-1:0] iaddr_t;

  typedef enum logic [1:0] {
    F_RUN   = 2'd0,
    F_WAIT  = 2'd1,
    F_DRAIN = 2'd2
  } fetch_state_e;

  localparam insn_t NOP_INSN = 16'h0000;

  // Number of instructions consumed when S0 presents the given valid mask.
  function automatic logic [1:0] pop_amount(input logic [1:0] valid);
    return {1'b0, valid[0]} + {1'b0, valid[1]};
  endfunction

endpackage

// File: rtl/dual_fetch_buffer_chk.sv
// Simulation-only invariants of the fetch buffer.
module dual_fetch_buffer_chk
  import core_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CW    = 4
) (
  input logic          clk,
  input logic          rst_n,
  input fetch_state_e  state_i,
  input logic          mem_rvalid_i,
  input logic [CW-1:0] count_i
);

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    count_i <= CW'(DEPTH));

  a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (!rst_n)
    !(state_i == F_RUN && mem_rvalid_i));

endmodule

// File: rtl/pair_fifo.sv
// Circular instruction buffer with 2-wide push/pop and head/head+1 read ports.
module pair_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 8,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic [1:0]    push_n_i,
  input  logic [W-1:0]  push_d0_i,
  input  logic [W-1:0]  push_d1_i,
  input  logic [1:0]    pop_n_i,
  output logic [W-1:0]  head0_o,
  output logic [W-1:0]  head1_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;

  // Next pointers and occupancy; a flush empties the buffer regardless of traffic.
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (flush_i) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      wr_d    = wr_q + PW'(push_n_i);
      rd_d    = rd_q + PW'(pop_n_i);
      count_d = count_q + CW'(push_n_i) - CW'(pop_n_i);
    end
  end

  // Pointer and occupancy registers; pointers wrap modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Storage writes; a pair landing at the top slot splits into DEPTH-1 and 0.
  always_ff @(posedge clk) begin
    if (!flush_i && push_n_i != 2'd0) begin
      mem_q[wr_q] <= push_d0_i;
      if (push_n_i == 2'd2) begin
        mem_q[wr_q + PW'(1)] <= push_d1_i;
      end
    end
  end

  assign head0_o = mem_q[rd_q];
  assign head1_o = mem_q[rd_q + PW'(1)];
  assign count_o = count_q;

endmodule

// File: rtl/dual_fetch_buffer.sv
// Instruction-pair fetch unit feeding the S0 decode pair of the dual-issue pipeline.
module dual_fetch_buffer
  import core_pkg::*;
#(
  parameter int INSN_W = 16,
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [2*INSN_W-1:0] mem_rdata,
  output logic [INSN_W-1:0] s0_insn0,
  output logic [INSN_W-1:0] s0_insn1,
  output logic [1:0]        s0_valid,
  input  logic              fetch_next
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] fetch_pc_q;
  logic              skip_lo_q;
  logic              mem_req_q;
  logic [ADDR_W-1:0] mem_addr_q;

  logic [CW-1:0]     count_s;
  logic [INSN_W-1:0] head0_s, head1_s;
  logic [INSN_W-1:0] push_d0_s;
  logic [1:0]        valid_s, push_n_s, pop_n_s;
  logic              accept_s, can_req_s;

  // S0 presentation, push/pop amounts and the request permission.
  always_comb begin
    valid_s   = 2'b00;
    push_n_s  = 2'd0;
    pop_n_s   = 2'd0;
    push_d0_s = mem_rdata[INSN_W-1:0];
    if (count_s >= CW'(2)) begin
      valid_s = 2'b11;
    end else if (count_s == CW'(1)) begin
      valid_s = 2'b01;
    end else begin
      valid_s = 2'b00;
    end
    if (fetch_next && !redirect) begin
      pop_n_s = pop_amount(valid_s);
    end else begin
      pop_n_s = 2'd0;
    end
    accept_s = (state_q == F_WAIT) && mem_rvalid && !redirect;
    if (accept_s) begin
      push_n_s = skip_lo_q ? 2'd1 : 2'd2;
    end else begin
      push_n_s = 2'd0;
    end
    if (skip_lo_q) begin
      push_d0_s = mem_rdata[2*INSN_W-1:INSN_W];
    end else begin
      push_d0_s = mem_rdata[INSN_W-1:0];
    end
    can_req_s = !halt && !redirect && (count_s <= CW'(DEPTH - 2));
  end

  // Fetch FSM: one outstanding request, stale responses dropped after a redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= F_RUN;
      fetch_pc_q <= '0;
      skip_lo_q  <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      mem_req_q <= 1'b0;
      if (redirect) begin
        fetch_pc_q <= {redirect_pc[ADDR_W-1:1], 1'b0};
        skip_lo_q  <= redirect_pc[0];
        case (state_q)
          F_WAIT, F_DRAIN: state_q <= mem_rvalid ? F_RUN : F_DRAIN;
          default:         state_q <= F_RUN;
        endcase
      end else begin
        case (state_q)
          F_RUN: begin
            if (can_req_s) begin
              mem_req_q  <= 1'b1;
              mem_addr_q <= fetch_pc_q;
              state_q    <= F_WAIT;
            end
          end
          F_WAIT: begin
            if (mem_rvalid) begin
              fetch_pc_q <= fetch_pc_q + ADDR_W'(2);
              skip_lo_q  <= 1'b0;
              state_q    <= F_RUN;
            end
          end
          F_DRAIN: begin
            if (mem_rvalid) begin
              state_q <= F_RUN;
            end
          end
          default: state_q <= F_RUN;
        endcase
      end
    end
  end

  pair_fifo #(
    .W     (INSN_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (redirect),
    .push_n_i  (push_n_s),
    .push_d0_i (push_d0_s),
    .push_d1_i (mem_rdata[2*INSN_W-1:INSN_W]),
    .pop_n_i   (pop_n_s),
    .head0_o   (head0_s),
    .head1_o   (head1_s),
    .count_o   (count_s)
  );

  dual_fetch_buffer_chk #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_chk (
    .clk          (clk),
    .rst_n        (rst_n),
    .state_i      (state_q),
    .mem_rvalid_i (mem_rvalid),
    .count_i      (count_s)
  );

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign s0_valid = valid_s;
  assign s0_insn0 = valid_s[0] ? head0_s : NOP_INSN;
  assign s0_insn1 = valid_s[1] ? head1_s : NOP_INSN;

endmodule

// File: tb/tb_dual_fetch_buffer.sv
// Directed and randomized bench for dual_fetch_buffer with a queue-based reference model.
module tb_dual_fetch_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd = 1'b0;
  logic [8:0]  rpc = 9'd0;
  logic        hlt = 1'b0;
  logic        mem_req;
  logic [8:0]  mem_addr;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic [15:0] s0_insn0, s0_insn1;
  logic [1:0]  s0_valid;
  logic        fn = 1'b0;

  int checks = 0;
  int errors = 0;

  // memory responder
  int cd = 0;
  int next_lat = 1;
  logic [8:0] raddr = 9'd0;
  int addr_log[$];

  // reference model
  logic [15:0] m_q[$];
  int   m_pc = 0;
  logic m_skip = 1'b0;
  logic m_pend = 1'b0;
  logic m_disc = 1'b0;
  logic exp_req = 1'b0;
  int   exp_addr = 0;

  dual_fetch_buffer #(.INSN_W(16), .ADDR_W(9), .DEPTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .redirect    (rd),
    .redirect_pc (rpc),
    .halt        (hlt),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .s0_insn0    (s0_insn0),
    .s0_insn1    (s0_insn1),
    .s0_valid    (s0_valid),
    .fetch_next  (fn)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mval(input int a);
    logic [8:0] aa;
    aa = 9'(a);
    return {aa[6:0], aa} ^ 16'h5A3C;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    int sz;
    sz = m_q.size();
    exp_req = 1'b0;
    if (rd) begin
      m_q.delete();
      m_pc = int'(rpc) & 32'h1FE;
      m_skip = rpc[0];
      if (m_pend && mem_rvalid) begin
        m_pend = 1'b0;
        m_disc = 1'b0;
      end else if (m_pend) begin
        m_disc = 1'b1;
      end
    end else begin
      if (fn) repeat ((sz >= 2) ? 2 : sz) void'(m_q.pop_front());
      if (m_pend && mem_rvalid) begin
        if (!m_disc) begin
          if (!m_skip) m_q.push_back(mem_rdata[15:0]);
          m_q.push_back(mem_rdata[31:16]);
          m_pc = (m_pc + 2) % 512;
          m_skip = 1'b0;
        end
        m_pend = 1'b0;
        m_disc = 1'b0;
      end else if (!m_pend && !hlt && sz <= 6) begin
        exp_req = 1'b1;
        exp_addr = m_pc;
        m_pend = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    logic [1:0] ev;
    ev = (m_q.size() >= 2) ? 2'b11 : ((m_q.size() == 1) ? 2'b01 : 2'b00);
    chk("mem_req", 32'(mem_req), 32'(exp_req));
    if (exp_req) chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
    chk("s0_valid", 32'(s0_valid), 32'(ev));
    if (ev[0]) chk("s0_insn0", 32'(s0_insn0), 32'(m_q[0]));
    if (ev[1]) chk("s0_insn1", 32'(s0_insn1), 32'(m_q[1]));
  endtask

  // One clock: drive memory, advance DUT and model, check on the falling edge.
  task automatic tick();
    mem_rvalid = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata = {mval(int'(raddr) + 1), mval(int'(raddr))};
      end
    end
    if (mem_req) begin
      cd = (next_lat > 0) ? next_lat : $urandom_range(1, 3);
      raddr = mem_addr;
      addr_log.push_back(int'(mem_addr));
    end
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_req(input string tag);
    int n0;
    int k;
    n0 = addr_log.size();
    k = 0;
    while (addr_log.size() == n0 && k < 40) begin
      tick();
      k++;
    end
    if (addr_log.size() == n0) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_valid(input string tag);
    int k;
    k = 0;
    while (s0_valid == 2'b00 && k < 40) begin
      tick();
      k++;
    end
    if (s0_valid == 2'b00) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_cd1(input string tag);
    int k;
    k = 0;
    while (cd != 1 && k < 40) begin
      tick();
      k++;
    end
    if (cd != 1) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int exp_pc;
    // reset state
    @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_s0_valid", 32'(s0_valid), 32'd0);
    chk("rst_s0_insn0", 32'(s0_insn0), 32'd0);
    chk("rst_s0_insn1", 32'(s0_insn1), 32'd0);
    rst_n = 1'b1;
    check_outputs();

    // 1-cycle memory, fetch_next always high
    next_lat = 1;
    fn = 1'b1;
    wait_valid("first_pair");
    chk("first_valid", 32'(s0_valid), 32'd3);
    chk("first_insn0", 32'(s0_insn0), 32'(mval(0)));
    chk("first_insn1", 32'(s0_insn1), 32'(mval(1)));
    tick();
    wait_valid("second_pair");
    chk("second_insn0", 32'(s0_insn0), 32'(mval(2)));
    chk("second_insn1", 32'(s0_insn1), 32'(mval(3)));
    ticks(6);
    chk("addr_seq0", 32'(addr_log[0]), 32'd0);
    chk("addr_seq1", 32'(addr_log[1]), 32'd2);
    chk("addr_seq2", 32'(addr_log[2]), 32'd4);

    // back-pressure until full, then release
    fn = 1'b0;
    ticks(30);
    chk("full_valid", 32'(s0_valid), 32'd3);
    fn = 1'b1;
    ticks(30);

    // redirect to odd PC while a slow response is outstanding
    next_lat = 3;
    fn = 1'b0;
    wait_req("rdr_req");
    rd = 1'b1;
    rpc = 9'd5;
    fn = 1'b1;
    tick();
    rd = 1'b0;
    chk("rdr_empty", 32'(s0_valid), 32'd0);
    wait_req("rdr_next");
    chk("rdr_addr", 32'(addr_log[addr_log.size() - 1]), 32'd4);
    wait_valid("rdr_first");
    chk("rdr_valid1", 32'(s0_valid), 32'd1);
    chk("rdr_insn5", 32'(s0_insn0), 32'(mval(5)));
    tick();
    wait_valid("rdr_pair");
    chk("rdr_valid2", 32'(s0_valid), 32'd3);
    chk("rdr_insn6", 32'(s0_insn0), 32'(mval(6)));
    chk("rdr_insn7", 32'(s0_insn1), 32'(mval(7)));

    // redirect coinciding with mem_rvalid and fetch_next
    next_lat = 2;
    fn = 1'b0;
    ticks(4);
    wait_cd1("coinc");
    rd = 1'b1;
    rpc = 9'd300;
    fn = 1'b1;
    tick();
    rd = 1'b0;
    chk("coinc_empty", 32'(s0_valid), 32'd0);
    wait_req("coinc_req");
    chk("coinc_addr", 32'(addr_log[addr_log.size() - 1]), 32'd300);
    ticks(10);

    // wrap: odd start leaves wr_ptr odd so a pair lands on slots 7 and 0
    next_lat = 1;
    rd = 1'b1;
    rpc = 9'd1;
    fn = 1'b0;
    tick();
    rd = 1'b0;
    ticks(15);
    fn = 1'b1;
    tick();
    fn = 1'b0;
    ticks(8);
    fn = 1'b1;
    ticks(20);

    // halt with one request outstanding
    next_lat = 3;
    wait_req("halt_req");
    hlt = 1'b1;
    ticks(25);
    chk("halt_drained", 32'(s0_valid), 32'd0);
    exp_pc = m_pc;
    hlt = 1'b0;
    wait_req("halt_resume");
    chk("halt_resume_addr", 32'(addr_log[addr_log.size() - 1]), 32'(exp_pc));

    // randomized traffic including PC wrap near the top of memory
    next_lat = 0;
    for (int i = 0; i < 600; i++) begin
      fn  = ($urandom_range(0, 3) != 0);
      hlt = ($urandom_range(0, 15) == 0);
      rd  = ($urandom_range(0, 24) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? 9'(508 + $urandom_range(0, 3)) : 9'($urandom_range(0, 511));
      tick();
    end
    rd = 1'b0;
    hlt = 1'b0;
    ticks(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
